filter_sp_writer: RTL and testbench

//  Write-side controller for the filter scratchpad. It accepts a valid/ready stream of filter words and

---
 rtl/conv_pkg.sv | 17 +
 rtl/filter_sp_writer_if.sv | 43 ++++
 rtl/wrap_addr_counter.sv | 49 ++++
 rtl/filter_sp_writer.sv | 154 +++++++++++++++
 tb/tb_filter_sp_writer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the filter scratchpad write and read sides.
// Holds the controller state encoding and the default data, address and
// filter-count widths, so both sides agree on them.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NF_WIDTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } wr_state_e;

endpackage

// File: rtl/filter_sp_writer_if.sv
// Bundle of the filter writer's control, stream, scratchpad-write and
// handshake signals.
//   slave  : the writer itself (filter_sp_writer)
//   master : whatever drives the job, the stream and the consume pulse
//
// Signals:
//   start, filter_size, num_filters : job request (sampled in IDLE)
//   in_data, in_valid, in_ready     : input word stream
//   wr_en, wr_addr, wr_data         : scratchpad write port
//   filter_loaded, filter_consumed  : filter resident / filter used
//   filter_idx, busy, all_done      : job status
interface filter_sp_writer_if #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = conv_pkg::ADDR_WIDTH_DEF,
  parameter int NF_WIDTH   = conv_pkg::NF_WIDTH_DEF
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] filter_size;
  logic [NF_WIDTH-1:0]   num_filters;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  filter_loaded;
  logic                  filter_consumed;
  logic [NF_WIDTH-1:0]   filter_idx;
  logic                  busy;
  logic                  all_done;

  modport slave (
    input  start, filter_size, num_filters, in_data, in_valid, filter_consumed,
    output in_ready, wr_en, wr_addr, wr_data, filter_loaded, filter_idx, busy, all_done
  );

  modport master (
    output start, filter_size, num_filters, in_data, in_valid, filter_consumed,
    input  in_ready, wr_en, wr_addr, wr_data, filter_loaded, filter_idx, busy, all_done
  );

endinterface

// File: rtl/wrap_addr_counter.sv
// Wrapping address counter used as the scratchpad write pointer.
// Counts 0..limit-1 on inc and wraps back to 0; last flags that the current
// count is the final address before the wrap.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (has priority over inc)
//   inc      : advance the count
//   limit    : number of addresses in one pass
//   cnt      : current address
//   last     : cnt+1 == limit
module wrap_addr_counter #(
  parameter int ADDR_WIDTH = conv_pkg::ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   cnt_plus1;

  // One extra bit so a limit of 2^ADDR_WIDTH-1 compares without overflow.
  assign cnt_plus1 = {1'b0, cnt_q} + (ADDR_WIDTH+1)'(1);
  assign last      = (cnt_plus1 == {1'b0, limit});
  assign cnt       = cnt_q;

  // Next count: clear wins, otherwise step and wrap at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_plus1[ADDR_WIDTH-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filter_sp_writer.sv
// Write-side controller for the filter scratchpad.
// Accepts a valid/ready stream of filter words and writes one filter of
// filter_size words at addresses 0..filter_size-1, then holds it until the
// read side pulses filter_consumed. Repeats for num_filters filters.
//   clk, rst : clock, asynchronous active-high reset
//   sp       : filter_sp_writer_if slave port (job request, input stream,
//              scratchpad write port, loaded/consumed handshake, status)
module filter_sp_writer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NF_WIDTH   = NF_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  filter_sp_writer_if.slave sp
);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] filter_size_q, filter_size_d;
  logic [NF_WIDTH-1:0]   num_filters_q, num_filters_d;
  logic [NF_WIDTH-1:0]   filter_idx_q, filter_idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  filter_loaded_q, filter_loaded_d;
  logic                  busy_q, busy_d;
  logic                  all_done_q, all_done_d;

  logic [ADDR_WIDTH-1:0] wptr;
  logic                  wptr_last;
  logic                  handshake;
  logic                  start_ok;
  logic                  consume;
  logic                  last_filter;
  logic                  cnt_clr;
  logic [NF_WIDTH:0]     idx_plus1;

  assign handshake   = (state_q == LOAD) && sp.in_valid;
  assign start_ok    = (state_q == IDLE) && sp.start;
  assign consume     = (state_q == HOLD) && sp.filter_consumed;
  assign idx_plus1   = {1'b0, filter_idx_q} + (NF_WIDTH+1)'(1);
  assign last_filter = (idx_plus1 == {1'b0, num_filters_q});

  // The pointer restarts at 0 for a new job and for each following filter.
  assign cnt_clr = start_ok || (consume && !last_filter);

  wrap_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (handshake),
    .limit (filter_size_q),
    .cnt   (wptr),
    .last  (wptr_last)
  );

  // Next-state and next-output logic for the load/hold controller.
  always_comb begin
    state_d         = state_q;
    filter_size_d   = filter_size_q;
    num_filters_d   = num_filters_q;
    filter_idx_d    = filter_idx_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    filter_loaded_d = filter_loaded_q;
    all_done_d      = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (sp.start) begin
          filter_size_d = sp.filter_size;
          num_filters_d = sp.num_filters;
          filter_idx_d  = '0;
          state_d = ((sp.filter_size != '0) && (sp.num_filters != '0)) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (handshake) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wptr;
          wr_data_d = sp.in_data;
          if (wptr_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // filter_loaded rises one cycle after the final write becomes visible.
        if (sp.filter_consumed) begin
          filter_loaded_d = 1'b0;
          if (last_filter) begin
            state_d = DONE;
          end else begin
            filter_idx_d = idx_plus1[NF_WIDTH-1:0];
            state_d      = LOAD;
          end
        end else begin
          filter_loaded_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any job in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      filter_size_q   <= '0;
      num_filters_q   <= '0;
      filter_idx_q    <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      filter_loaded_q <= 1'b0;
      busy_q          <= 1'b0;
      all_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      filter_size_q   <= filter_size_d;
      num_filters_q   <= num_filters_d;
      filter_idx_q    <= filter_idx_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      filter_loaded_q <= filter_loaded_d;
      busy_q          <= busy_d;
      all_done_q      <= all_done_d;
    end
  end

  // Stream ready follows the state directly so words flow back to back.
  assign sp.in_ready      = (state_q == LOAD);
  assign sp.wr_en         = wr_en_q;
  assign sp.wr_addr       = wr_addr_q;
  assign sp.wr_data       = wr_data_q;
  assign sp.filter_loaded = filter_loaded_q;
  assign sp.filter_idx    = filter_idx_q;
  assign sp.busy          = busy_q;
  assign sp.all_done      = all_done_q;

endmodule

// File: tb/tb_filter_sp_writer.sv
// Directed self-checking bench for filter_sp_writer.
// Every word driven into the stream pushes its expected scratchpad write
// (address, data, filter index) onto a queue; a monitor pops and compares
// on each wr_en. Control and status outputs are checked at directed steps.
module tb_filter_sp_writer;

  logic clk;
  logic rst;

  filter_sp_writer_if bus ();

  filter_sp_writer dut (
    .clk (clk),
    .rst (rst),
    .sp  (bus.slave)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given job parameters for one cycle.
  task automatic applyStimulus(input int fs, input int nf);
    bus.start       = 1'b1;
    bus.filter_size = 5'(fs);
    bus.num_filters = 4'(nf);
    tick();
    bus.start = 1'b0;
  endtask

  // Stream n words, either back to back or with an idle cycle after each.
  task automatic send_words(input int n, input int idx, input bit gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom) | 16'h0001;
      e.addr = 5'(k);
      e.data = bus.in_data;
      e.idx  = 4'(idx);
      sb.push_back(e);
      tick();
      if (gap) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_loaded(input string tag);
    for (int i = 0; i < 50 && bus.filter_loaded !== 1'b1; i++) tick();
    checkOutput(tag, 32'(bus.filter_loaded), 32'd1);
  endtask

  task automatic pulse_consumed();
    bus.filter_consumed = 1'b1;
    tick();
    bus.filter_consumed = 1'b0;
  endtask

  // Scoreboard monitor: every write must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("wr_unexpected", 32'(bus.wr_en), 32'd0);
      end else begin
        mon_item = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(mon_item.addr));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(mon_item.data));
        checkOutput("wr_idx",  32'(bus.filter_idx), 32'(mon_item.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.filter_size = '0;
    bus.num_filters = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.filter_consumed = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_all_done", 32'(bus.all_done), 32'd0);
    checkOutput("rst_filter_idx", 32'(bus.filter_idx), 32'd0);
    checkOutput("rst_loaded", 32'(bus.filter_loaded), 32'd0);
    rst = 1'b0;
    tick();

    // Two filters of three words, stream always valid
    applyStimulus(3, 2);
    checkOutput("t2_busy", 32'(bus.busy), 32'd1);
    checkOutput("t2_in_ready", 32'(bus.in_ready), 32'd1);
    send_words(3, 0, 1'b0);
    checkOutput("t2_hold_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t2_last_wr_en", 32'(bus.wr_en), 32'd1);
    checkOutput("t2_loaded_early", 32'(bus.filter_loaded), 32'd0);
    tick();
    checkOutput("t2_loaded_t2", 32'(bus.filter_loaded), 32'd1);
    checkOutput("t2_wr_en_idle", 32'(bus.wr_en), 32'd0);
    tick();
    tick();
    checkOutput("t2_loaded_held", 32'(bus.filter_loaded), 32'd1);
    pulse_consumed();
    checkOutput("t2_loaded_clr", 32'(bus.filter_loaded), 32'd0);
    checkOutput("t2_idx1", 32'(bus.filter_idx), 32'd1);
    checkOutput("t2_reload_ready", 32'(bus.in_ready), 32'd1);
    send_words(3, 1, 1'b0);
    wait_loaded("t2_loaded_f1");
    pulse_consumed();
    checkOutput("t2_done_busy", 32'(bus.busy), 32'd1);
    checkOutput("t2_done_pre", 32'(bus.all_done), 32'd0);
    tick();
    checkOutput("t2_all_done", 32'(bus.all_done), 32'd1);
    checkOutput("t2_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("t2_all_done_1cyc", 32'(bus.all_done), 32'd0);
    checkOutput("t2_idx_kept", 32'(bus.filter_idx), 32'd1);

    // Stream toggling valid
    applyStimulus(4, 1);
    send_words(4, 0, 1'b1);
    wait_loaded("t3_loaded");
    pulse_consumed();
    tick();
    checkOutput("t3_all_done", 32'(bus.all_done), 32'd1);
    tick();

    // Largest filter, address wrap between filters
    applyStimulus(31, 2);
    send_words(31, 0, 1'b0);
    wait_loaded("t4_loaded_f0");
    pulse_consumed();
    checkOutput("t4_idx1", 32'(bus.filter_idx), 32'd1);
    send_words(31, 1, 1'b0);
    wait_loaded("t4_loaded_f1");
    pulse_consumed();
    tick();
    checkOutput("t4_all_done", 32'(bus.all_done), 32'd1);
    tick();

    // Zero filters: straight to DONE
    applyStimulus(3, 0);
    checkOutput("t5_busy", 32'(bus.busy), 32'd1);
    checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t5_done_pre", 32'(bus.all_done), 32'd0);
    checkOutput("t5_idx0", 32'(bus.filter_idx), 32'd0);
    tick();
    checkOutput("t5_all_done", 32'(bus.all_done), 32'd1);
    checkOutput("t5_busy_low", 32'(bus.busy), 32'd0);
    checkOutput("t5_wr_en", 32'(bus.wr_en), 32'd0);
    tick();
    checkOutput("t5_all_done_1cyc", 32'(bus.all_done), 32'd0);

    // Ignored start / consumed, single-word filters
    applyStimulus(1, 2);
    pulse_consumed();
    checkOutput("t6_load_consume_idx", 32'(bus.filter_idx), 32'd0);
    checkOutput("t6_load_consume_ready", 32'(bus.in_ready), 32'd1);
    send_words(1, 0, 1'b0);
    wait_loaded("t6_loaded_f0");
    bus.start = 1'b1;
    bus.filter_size = 5'd5;
    bus.num_filters = 4'd7;
    tick();
    tick();
    bus.start = 1'b0;
    checkOutput("t6_hold_start_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t6_hold_start_loaded", 32'(bus.filter_loaded), 32'd1);
    checkOutput("t6_hold_start_idx", 32'(bus.filter_idx), 32'd0);
    pulse_consumed();
    checkOutput("t6_idx1", 32'(bus.filter_idx), 32'd1);
    send_words(1, 1, 1'b0);
    wait_loaded("t6_loaded_f1");
    pulse_consumed();
    tick();
    checkOutput("t6_all_done", 32'(bus.all_done), 32'd1);
    tick();

    // Reset in the middle of LOAD
    applyStimulus(5, 1);
    send_words(2, 0, 1'b0);
    tick();
    checkOutput("t1_sb_drained", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    #2;
    checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t1_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("t1_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("t1_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("t1_busy", 32'(bus.busy), 32'd0);
    checkOutput("t1_loaded", 32'(bus.filter_loaded), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t1_idle_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(2, 1);
    send_words(2, 0, 1'b0);
    wait_loaded("t1_loaded");
    pulse_consumed();
    tick();
    checkOutput("t1_all_done", 32'(bus.all_done), 32'd1);
    tick();
    tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
